rr_mux_arbiter8: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8:1 data mux path between 8 requesters.
- Each cycle it picks one eligible requester, drives the mux select, and captures that lane into a registered output stage.
- The output stage uses a valid/ready handshake toward the downstream consumer.
- Optional per-requester lock gives bounded bursts to one requester; the MAX_BURST cap prevents starvation of the others.

---
 rtl/rr_mux_arbiter8.sv | 142 ++++++++++++++
 tb/tb_rr_mux_arbiter8.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter8
// Description : Round-robin arbiter that shares one 8:1 data mux between
//               eight requesters. The winning lane goes into a registered
//               valid/ready output stage. A requester may lock for bounded
//               bursts of up to MAX_BURST transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter8 #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            req,
    input  logic [7:0]            lock,
    input  logic [8*DATA_W-1:0]   data_in,
    output logic [7:0]            ack,
    output logic [DATA_W-1:0]     out_data,
    output logic [2:0]            out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int                CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  c_max_burst = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  c_one       = CNT_W'(1);

    // Registered state
    logic [DATA_W-1:0] out_data_q,    out_data_d;
    logic [2:0]        out_sel_q,     out_sel_d;
    logic              out_valid_q,   out_valid_d;
    logic [2:0]        ptr_q,         ptr_d;
    logic              lock_active_q, lock_active_d;
    logic [2:0]        lock_id_q,     lock_id_d;
    logic [CNT_W-1:0]  burst_cnt_q,   burst_cnt_d;

    // Arbitration wires
    logic [7:0]        w_elig;
    logic              w_lock_hold;
    logic              w_found;
    logic [2:0]        w_win;
    logic              w_load;
    logic [CNT_W-1:0]  w_next_cnt;

    // Eligibility: a held lock with its requester still asking restricts the
    // choice to that requester; otherwise every requester competes.
    always_comb begin
        w_lock_hold = lock_active_q & req[lock_id_q];
        w_elig      = w_lock_hold ? (8'b1 << lock_id_q) : req;
    end

    // Round-robin scan starting at ptr and wrapping modulo 8.
    always_comb begin
        logic [2:0] idx;
        w_found = 1'b0;
        w_win   = 3'd0;
        idx     = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    // Load when the output stage is free (or being drained) and someone won.
    // Reset forces ack low so no transfer is claimed during reset.
    always_comb begin
        w_load = (~out_valid_q | out_ready) & w_found & ~reset;
        ack    = w_load ? (8'b1 << w_win) : 8'b0;
    end

    // Next-state logic for the output stage, pointer and lock tracking.
    always_comb begin
        out_data_d    = out_data_q;
        out_sel_d     = out_sel_q;
        out_valid_d   = out_valid_q;
        ptr_d         = ptr_q;
        lock_active_d = lock_active_q;
        lock_id_d     = lock_id_q;
        burst_cnt_d   = burst_cnt_q;

        // Burst length this grant would reach if the winner keeps its lock.
        w_next_cnt = (lock_active_q && (lock_id_q == w_win)) ? (burst_cnt_q + c_one) : c_one;

        if (w_load) begin
            out_data_d  = data_in[w_win*DATA_W +: DATA_W];
            out_sel_d   = w_win;
            out_valid_d = 1'b1;
            ptr_d       = w_win + 3'd1;
            if (lock[w_win] && (w_next_cnt < c_max_burst)) begin
                lock_active_d = 1'b1;
                lock_id_d     = w_win;
                burst_cnt_d   = w_next_cnt;
            end else begin
                lock_active_d = 1'b0;
                burst_cnt_d   = '0;
            end
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            // Locked requester withdrew: give up the lock at this edge.
            if (lock_active_q && !req[lock_id_q]) begin
                lock_active_d = 1'b0;
                burst_cnt_d   = '0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q    <= '0;
            out_sel_q     <= 3'd0;
            out_valid_q   <= 1'b0;
            ptr_q         <= 3'd0;
            lock_active_q <= 1'b0;
            lock_id_q     <= 3'd0;
            burst_cnt_q   <= '0;
        end else begin
            out_data_q    <= out_data_d;
            out_sel_q     <= out_sel_d;
            out_valid_q   <= out_valid_d;
            ptr_q         <= ptr_d;
            lock_active_q <= lock_active_d;
            lock_id_q     <= lock_id_d;
            burst_cnt_q   <= burst_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign busy      = out_valid_q | lock_active_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arbiter8
// Description : Directed self-checking bench for rr_mux_arbiter8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter8;

    localparam int DATA_W = 8;

    logic                clk;
    logic                reset;
    logic [7:0]          req;
    logic [7:0]          lock;
    logic [8*DATA_W-1:0] data_in;
    logic [7:0]          ack;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          out_sel;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    int total = 0;
    int bad   = 0;

    rr_mux_arbiter8 #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .data_in   (data_in),
        .ack       (ack),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; drives and checks happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        req       = 8'hFF;
        lock      = 8'h00;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) data_in[i*DATA_W +: DATA_W] = 8'(8'h10 + i);

        // ---- Reset / idle ----
        #1;
        chk("rst_ack0", 32'(ack), 32'h00);
        tick();
        chk("rst_ack1", 32'(ack), 32'h00);
        tick();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  32'(out_data),  32'h00);
        chk("rst_sel",   32'(out_sel),   32'h0);
        chk("rst_ack2",  32'(ack),       32'h00);
        reset = 1'b0;
        req   = 8'h00;
        tick();
        chk("idle_valid", 32'(out_valid), 32'h0);
        chk("idle_busy",  32'(busy),      32'h0);
        chk("idle_ack",   32'(ack),       32'h00);

        // ---- Full rotation: ptr=0 ----
        req = 8'hFF;
        #1;
        for (int i = 0; i < 9; i++) begin
            chk("rot_ack",   32'(ack),       32'(8'b1 << (i % 8)));
            tick();
            chk("rot_sel",   32'(out_sel),   32'(i % 8));
            chk("rot_data",  32'(out_data),  32'(8'h10 + (i % 8)));
            chk("rot_valid", 32'(out_valid), 32'h1);
        end
        // last grant was 0 -> ptr=1
        req = 8'h00;
        tick();
        chk("rot_drain", 32'(out_valid), 32'h0);

        // ---- Backpressure: ptr=1 ----
        req       = 8'h24;
        out_ready = 1'b0;
        #1;
        chk("bp_ack_first", 32'(ack), 32'h04);
        tick();
        chk("bp_data_first", 32'(out_data), 32'h12);
        chk("bp_sel_first",  32'(out_sel),  32'h2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ack_hold",  32'(ack),      32'h00);
            tick();
            chk("bp_data_hold", 32'(out_data), 32'h12);
            chk("bp_valid",     32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ack_next", 32'(ack), 32'h20);
        tick();
        chk("bp_data_next", 32'(out_data), 32'h15);
        chk("bp_sel_next",  32'(out_sel),  32'h5);
        req = 8'h00;
        tick();
        chk("bp_drain", 32'(out_valid), 32'h0);

        // ---- Lock burst: ptr=6, MAX_BURST=4 ----
        req  = 8'h03;
        lock = 8'h01;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("lk_ack0", 32'(ack), 32'h01);
            tick();
            chk("lk_sel0", 32'(out_sel), 32'h0);
            if (i == 0) chk("lk_cnt1", 32'(dut.burst_cnt_q), 32'h1);
        end
        chk("lk_cnt_end",    32'(dut.burst_cnt_q),   32'h0);
        chk("lk_active_end", 32'(dut.lock_active_q), 32'h0);
        chk("lk_ack_rot", 32'(ack), 32'h02);
        tick();
        chk("lk_sel_rot", 32'(out_sel), 32'h1);
        chk("lk_ack_back", 32'(ack), 32'h01);
        tick();
        chk("lk_active_new", 32'(dut.lock_active_q), 32'h1);

        // ---- Lock release after 2 grants ----
        chk("rel_ack2", 32'(ack), 32'h01);
        tick();
        chk("rel_cnt2", 32'(dut.burst_cnt_q), 32'h2);
        req = 8'h02;
        #1;
        chk("rel_ack_switch", 32'(ack), 32'h02);
        tick();
        chk("rel_active", 32'(dut.lock_active_q), 32'h0);
        chk("rel_cnt",    32'(dut.burst_cnt_q),   32'h0);
        chk("rel_sel",    32'(out_sel),           32'h1);
        req = 8'h00;
        tick();

        // ---- Reset mid-operation: ptr=2 ----
        req       = 8'h01;
        lock      = 8'h01;
        out_ready = 1'b0;
        #1;
        chk("mid_ack", 32'(ack), 32'h01);
        tick();
        chk("mid_ack_bp", 32'(ack),  32'h00);
        chk("mid_busy",   32'(busy), 32'h1);
        chk("mid_lock",   32'(dut.lock_active_q), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'h00);
        tick();
        reset = 1'b0;
        req   = 8'h00;
        lock  = 8'h00;
        #1;
        chk("mid_valid", 32'(out_valid), 32'h0);
        chk("mid_data",  32'(out_data),  32'h00);
        chk("mid_sel",   32'(out_sel),   32'h0);
        chk("mid_busyr", 32'(busy),      32'h0);
        chk("mid_ptr",   32'(dut.ptr_q), 32'h0);
        chk("mid_cnt",   32'(dut.burst_cnt_q), 32'h0);
        req       = 8'h80;
        out_ready = 1'b1;
        #1;
        chk("post_ack", 32'(ack), 32'h80);
        tick();
        chk("post_sel",  32'(out_sel),  32'h7);
        chk("post_data", 32'(out_data), 32'h17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
